cram_arbiter: RTL and testbench

Arbitrates the single write port of the palette CRAM between Z80 port writes and the DMA palette loader. Z80 strobes are buffered in a 2-entry FIFO so none are lost while DMA streams; DMA words move on a request/acknowledge handshake. The block drives the CRAM write pins of the video output stage (`cram_addr_in`/`cram_data_in`/`cram_we`) through registered outputs.

---
 rtl/cram_arbiter.sv | 84 ++++++++
 tb/tb_cram_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cram_arbiter.sv
// Palette CRAM write-port arbiter: buffers Z80 writes in a 2-entry FIFO and merges them with DMA words.
// Define CRAM_ARB_RR_EN for round-robin arbitration; the default build gives the CPU fixed priority.
module cram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [14:0] cpu_data,
  output logic        cpu_busy,
  output logic        cpu_ovf,
  input  logic        dma_req,
  input  logic [7:0]  dma_addr,
  input  logic [14:0] dma_data,
  output logic        dma_ack,
  output logic        cram_we,
  output logic [7:0]  cram_addr,
  output logic [14:0] cram_data
);

  typedef enum logic {GRANT_CPU, GRANT_DMA} grant_e;

  grant_e      last_grant;
  logic [1:0]  count;
  logic [22:0] fifo_q [2];

  logic       prefer_cpu;
  logic       grant_cpu;
  logic       grant_dma;
  logic       push;
  logic [1:0] count_after_pop;
  logic [1:0] count_next;

  always_comb begin
`ifdef CRAM_ARB_RR_EN
    prefer_cpu = (last_grant == GRANT_DMA);
`else
    // last_grant is tracked in both builds, but fixed priority never lets it change the outcome.
    prefer_cpu = 1'b1 | (last_grant == GRANT_DMA);
`endif
    grant_cpu       = (count != 2'd0) && (!dma_req || prefer_cpu);
    grant_dma       = dma_req && !grant_cpu;
    count_after_pop = count - {1'b0, grant_cpu};
    push            = cpu_we && (count_after_pop != 2'd2);
    count_next      = count_after_pop + {1'b0, push};
  end

  // A word in flight while reset is asserted must never be acknowledged.
  assign dma_ack = grant_dma && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_DMA;
      count      <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      cpu_busy   <= 1'b0;
      cpu_ovf    <= 1'b0;
      cram_we    <= 1'b0;
      cram_addr  <= '0;
      cram_data  <= '0;
    end else begin
      cram_we <= 1'b0;
      if (grant_cpu) begin
        cram_we                <= 1'b1;
        {cram_addr, cram_data} <= fifo_q[0];
        last_grant             <= GRANT_CPU;
        fifo_q[0]              <= fifo_q[1];
      end else if (grant_dma) begin
        cram_we    <= 1'b1;
        cram_addr  <= dma_addr;
        cram_data  <= dma_data;
        last_grant <= GRANT_DMA;
      end
      // The pushed entry lands behind whatever survives this cycle's pop.
      if (push) begin
        fifo_q[count_after_pop[0]] <= {cpu_addr, cpu_data};
      end
      count    <= count_next;
      cpu_busy <= (count_next == 2'd2);
      cpu_ovf  <= cpu_we && !push;
    end
  end

endmodule

// File: tb/tb_cram_arbiter.sv
// Randomized bench for cram_arbiter against a queue-based reference model.
// Honours CRAM_ARB_RR_EN the same way as the design.
module tb_cram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [14:0] cpu_data;
  logic        cpu_busy;
  logic        cpu_ovf;
  logic        dma_req;
  logic [7:0]  dma_addr;
  logic [14:0] dma_data;
  logic        dma_ack;
  logic        cram_we;
  logic [7:0]  cram_addr;
  logic [14:0] cram_data;

  cram_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_busy(cpu_busy), .cpu_ovf(cpu_ovf),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
    .cram_we(cram_we), .cram_addr(cram_addr), .cram_data(cram_data)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: pending CPU writes in order, who won last, and the expected registered outputs.
  logic [22:0] cpuQueue [$];
  bit          lastWasCpu;
  logic        expWe;
  logic [7:0]  expAddr;
  logic [14:0] expData;
  logic        expBusy;
  logic        expOvf;

  // DMA source state: a word stays put until it is acknowledged.
  bit          dReq;
  bit          lastAck;
  logic [7:0]  dNext;
  logic [7:0]  dA;
  logic [14:0] dD;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkRegs();
    checkOutput("cram_we",   32'(cram_we),   32'(expWe));
    checkOutput("cram_addr", 32'(cram_addr), 32'(expAddr));
    checkOutput("cram_data", 32'(cram_data), 32'(expData));
    checkOutput("cpu_busy",  32'(cpu_busy),  32'(expBusy));
    checkOutput("cpu_ovf",   32'(cpu_ovf),   32'(expOvf));
  endtask

  task automatic modelReset();
    cpuQueue.delete();
    lastWasCpu = 1'b0;
    expWe   = 1'b0;
    expAddr = '0;
    expData = '0;
    expBusy = 1'b0;
    expOvf  = 1'b0;
  endtask

  // One clock: drive inputs after the falling edge, predict, check ack before the rising edge, regs after it.
  task automatic applyStimulus(input bit we, input logic [7:0] a, input logic [14:0] d, input bit wantReq);
    bit cpuWins;
    bit ackExp;
    logic [22:0] head;
    if (!(dReq && !lastAck) && wantReq) begin
      dA = dNext;
      dNext++;
      dD = 15'($urandom);
    end
    dReq = wantReq;
    cpu_we   = we;
    cpu_addr = a;
    cpu_data = d;
    dma_req  = dReq;
    dma_addr = dA;
    dma_data = dD;
    #1;
`ifdef CRAM_ARB_RR_EN
    cpuWins = (cpuQueue.size() > 0) && !(dReq && lastWasCpu);
`else
    cpuWins = (cpuQueue.size() > 0);
`endif
    ackExp = dReq && !cpuWins;
    checkOutput("dma_ack", 32'(dma_ack), 32'(ackExp));
    lastAck = ackExp;
    expWe = 1'b0;
    if (cpuWins) begin
      head = cpuQueue.pop_front();
      {expAddr, expData} = head;
      expWe = 1'b1;
      lastWasCpu = 1'b1;
    end else if (ackExp) begin
      expAddr = dA;
      expData = dD;
      expWe = 1'b1;
      lastWasCpu = 1'b0;
    end
    expOvf = 1'b0;
    if (we) begin
      if (cpuQueue.size() < 2) cpuQueue.push_back({a, d});
      else expOvf = 1'b1;
    end
    expBusy = (cpuQueue.size() == 2);
    @(negedge clk);
    checkRegs();
  endtask

  // Reset asserted mid-cycle: outputs must clear at once and no ack may appear.
  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkRegs();
    checkOutput("dma_ack_in_reset", 32'(dma_ack), 32'd0);
    lastAck = 1'b0;
    @(negedge clk);
    checkRegs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    dma_req = 1'b0; dma_addr = '0; dma_data = '0;
    dReq = 1'b0; lastAck = 1'b0; dNext = '0; dA = '0; dD = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkRegs();
    checkOutput("dma_ack_reset", 32'(dma_ack), 32'd0);
    rst = 1'b0;

    $display("[TB] isolated CPU write");
    applyStimulus(1'b1, 8'h12, 15'h7FFF, 1'b0);
    applyStimulus(1'b0, 8'h00, 15'h0000, 1'b0);
    checkOutput("iso_we_cycle2", 32'(cram_we), 32'd1);
    checkOutput("iso_addr", 32'(cram_addr), 32'h12);
    checkOutput("iso_data", 32'(cram_data), 32'h7FFF);
    applyStimulus(1'b0, 8'h00, 15'h0000, 1'b0);
    checkOutput("iso_we_cycle3", 32'(cram_we), 32'd0);

    $display("[TB] DMA burst of 4");
    dNext = 8'h00;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 15'h0000, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 15'h0000, 1'b0);

    $display("[TB] CPU writes during DMA burst");
    dNext = 8'h40;
    for (int i = 0; i < 8; i++)
      applyStimulus(i >= 1 && i <= 3, 8'(8'h80 + i), 15'($urandom), 1'b1);
    applyStimulus(1'b0, 8'h00, 15'h0000, 1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 8'hA0, 15'h1234, 1'b1);
    applyStimulus(1'b1, 8'hA1, 15'h2345, 1'b1);
    applyStimulus(1'b1, 8'hA2, 15'h3456, 1'b1);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 15'h0000, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) doReset();
      else applyStimulus($urandom_range(0, 99) < 45, 8'($urandom), 15'($urandom),
                         $urandom_range(0, 99) < 65);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
